// File: rtl/rom_seq_multiplier_if.sv
// Handshake and ROM-lookup bundle for rom_seq_multiplier.
// The slave modport is the multiplier; the master side is the operand
// source / product sink, which also supplies the ROM response.
interface rom_seq_multiplier_if #(
  parameter int unsigned W = 24
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [7:0]     rom_addr;
  logic [7:0]     rom_data;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  modport slave (
    input  in_valid, a, b, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, product
  );

  modport master (
    output in_valid, a, b, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, product
  );
endinterface

// File: rtl/rom_seq_multiplier.sv
// Sequential unsigned multiplier built on a 4x4-bit nibble-product ROM.
// One nibble pair {a[i], b[j]} is looked up per cycle and the returned
// 8-bit product is shifted by 4*(i+j) and accumulated into a 2W-bit sum.
// A full product therefore takes NIB*NIB cycles, independent of the
// operand values.
module rom_seq_multiplier #(
  parameter int unsigned W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_seq_multiplier_if.slave   bus
);
  localparam int unsigned NIB = W / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned SW  = $clog2(2 * W) + 1;

  if ((W % 4) != 0 || W == 0) begin : g_width_check
    $error("rom_seq_multiplier: W must be a non-zero multiple of 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2*W-1:0]  r_acc;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [SW-1:0]   w_shamt;
  logic [2*W-1:0]  w_term;

  // Select the current nibble pair and align the ROM answer to its weight.
  always_comb begin
    w_a_nib = r_a[4*r_i +: 4];
    w_b_nib = r_b[4*r_j +: 4];
    w_shamt = SW'(4) * (SW'(r_i) + SW'(r_j));
    w_term  = {{(2*W-8){1'b0}}, bus.rom_data} << w_shamt;
  end

  assign bus.rom_addr  = (r_state == S_RUN) ? {w_a_nib, w_b_nib} : '0;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_acc;

  // Control FSM: accept operands, step through all nibble pairs, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + w_term;
          if (r_j == IW'(NIB - 1)) begin
            r_j <= '0;
            if (r_i == IW'(NIB - 1)) begin
              r_i         <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
